// File: rtl/ram_arb_seq.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arb_seq
//  Purpose  : Sequencer and write-port arbiter for the shared label RAM.
//             Clears the whole RAM after start, then shares the single write
//             port between the CGR and SQG requesters (round-robin) until
//             stop, and pulses done on the way back to IDLE.
//  Revision : 1.0 - initial release
// ============================================================================
module ram_arb_seq #(
   parameter int ADDR_LEN = 6,
   parameter int DATA_LEN = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  cgr_req,
   input  logic [ADDR_LEN+1:0]   cgr_addr,
   input  logic [DATA_LEN-1:0]   cgr_data,
   output logic                  cgr_gnt,
   input  logic                  sqg_req,
   input  logic [ADDR_LEN+1:0]   sqg_addr,
   input  logic [DATA_LEN-1:0]   sqg_data,
   output logic                  sqg_gnt,
   output logic                  ram_wr_en,
   output logic [ADDR_LEN+1:0]   ram_wr_addr,
   output logic [DATA_LEN-1:0]   ram_wr_data,
   output logic                  clr_busy,
   output logic                  ready,
   output logic                  done
);

   localparam int                AW     = ADDR_LEN + 2;
   // Last address of the clear sweep (DEPTH-1): the counter is AW bits wide.
   localparam logic [AW-1:0]     c_LAST = '1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_RUN   = 2'd2,
      S_FLUSH = 2'd3
   } state_t;

   state_t                 r_state;
   state_t                 w_next_state;
   logic [AW-1:0]          r_clr_cnt;
   // 1: SQG wins the next contention, 0: CGR wins (reset value).
   logic                   r_rr_sqg;
   logic                   w_cgr_gnt;
   logic                   w_sqg_gnt;
   logic                   r_wr_en;
   logic [AW-1:0]          r_wr_addr;
   logic [DATA_LEN-1:0]    r_wr_data;
   logic                   r_done;

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   // Next-state logic; start/stop are only honoured in their own states.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next_state = S_CLEAR;
         S_CLEAR: if (r_clr_cnt == c_LAST) w_next_state = S_RUN;
         S_RUN:   if (stop) w_next_state = S_FLUSH;
         S_FLUSH: w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Grant decode: only in RUN, and stop suppresses any grant that cycle.
   always_comb begin
      w_cgr_gnt = 1'b0;
      w_sqg_gnt = 1'b0;
      if (r_state == S_RUN && !stop) begin
         if (cgr_req && sqg_req) begin
            w_cgr_gnt = !r_rr_sqg;
            w_sqg_gnt =  r_rr_sqg;
         end else begin
            w_cgr_gnt = cgr_req;
            w_sqg_gnt = sqg_req;
         end
      end
   end

   // Clear-sweep address counter; wraps to 0 naturally after DEPTH-1.
   always_ff @(posedge CLK) begin
      if (RST)                     r_clr_cnt <= '0;
      else if (r_state == S_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
      else                         r_clr_cnt <= '0;
   end

   // Round-robin pointer: always favours the requester not granted last.
   always_ff @(posedge CLK) begin
      if (RST)            r_rr_sqg <= 1'b0;
      else if (w_cgr_gnt) r_rr_sqg <= 1'b1;
      else if (w_sqg_gnt) r_rr_sqg <= 1'b0;
   end

   // Registered RAM write port: clear writes, else the granted request;
   // address/data hold when nothing is written.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else if (r_state == S_CLEAR) begin
         r_wr_en   <= 1'b1;
         r_wr_addr <= r_clr_cnt;
         r_wr_data <= '0;
      end else if (w_cgr_gnt) begin
         r_wr_en   <= 1'b1;
         r_wr_addr <= cgr_addr;
         r_wr_data <= cgr_data;
      end else if (w_sqg_gnt) begin
         r_wr_en   <= 1'b1;
         r_wr_addr <= sqg_addr;
         r_wr_data <= sqg_data;
      end else begin
         r_wr_en   <= 1'b0;
      end
   end

   // Done pulse registered on the FLUSH -> IDLE transition.
   always_ff @(posedge CLK) begin
      if (RST) r_done <= 1'b0;
      else     r_done <= (r_state == S_FLUSH);
   end

   assign cgr_gnt     = w_cgr_gnt;
   assign sqg_gnt     = w_sqg_gnt;
   assign ram_wr_en   = r_wr_en;
   assign ram_wr_addr = r_wr_addr;
   assign ram_wr_data = r_wr_data;
   assign clr_busy    = (r_state == S_CLEAR);
   assign ready       = (r_state == S_RUN);
   assign done        = r_done;

   // The two grants are mutually exclusive and only appear in RUN.
   a_gnt_onehot: assert property (@(posedge CLK) disable iff (RST)
      !(cgr_gnt && sqg_gnt));
   a_gnt_in_run: assert property (@(posedge CLK) disable iff (RST)
      (cgr_gnt || sqg_gnt) |-> ready);

endmodule
`default_nettype wire

// File: tb/tb_ram_arb_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_arb_seq
//  Purpose  : Directed self-checking bench for ram_arb_seq (clear sweep,
//             single and contended grants, stop/flush/done, mid-clear reset,
//             ignored controls).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arb_seq;

   localparam int ADDR_LEN = 6;
   localparam int DATA_LEN = 8;
   localparam int AW       = ADDR_LEN + 2;
   localparam int DEPTH    = 1 << AW;

   logic                CLK = 1'b0;
   logic                RST = 1'b1;
   logic                start = 1'b0;
   logic                stop = 1'b0;
   logic                cgr_req = 1'b0;
   logic [AW-1:0]       cgr_addr = '0;
   logic [DATA_LEN-1:0] cgr_data = '0;
   logic                cgr_gnt;
   logic                sqg_req = 1'b0;
   logic [AW-1:0]       sqg_addr = '0;
   logic [DATA_LEN-1:0] sqg_data = '0;
   logic                sqg_gnt;
   logic                ram_wr_en;
   logic [AW-1:0]       ram_wr_addr;
   logic [DATA_LEN-1:0] ram_wr_data;
   logic                clr_busy;
   logic                ready;
   logic                done;

   int n_chk  = 0;
   int n_fail = 0;

   ram_arb_seq #(.ADDR_LEN(ADDR_LEN), .DATA_LEN(DATA_LEN)) dut (
      .CLK(CLK), .RST(RST), .start(start), .stop(stop),
      .cgr_req(cgr_req), .cgr_addr(cgr_addr), .cgr_data(cgr_data), .cgr_gnt(cgr_gnt),
      .sqg_req(sqg_req), .sqg_addr(sqg_addr), .sqg_data(sqg_data), .sqg_gnt(sqg_gnt),
      .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
      .clr_busy(clr_busy), .ready(ready), .done(done)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Called at the sample point of the first CLEAR cycle. Checks the sweep
   // write by write. abort_at >= 0 returns with the counter at that value.
   // poke=1 pulses stop, start and a request mid-sweep (all must be ignored).
   task automatic sweep(input int abort_at, input bit poke);
      for (int i = 0; i < DEPTH; i++) begin
         if (i == abort_at) return;
         check("clr_busy", clr_busy, 1);
         if (poke && i == 50) stop = 1'b1;
         if (poke && i == 51) stop = 1'b0;
         if (poke && i == 60) begin
            cgr_req = 1'b1; sqg_req = 1'b1; start = 1'b1;
            #1;
            check("no_cgr_gnt_clear", cgr_gnt, 0);
            check("no_sqg_gnt_clear", sqg_gnt, 0);
         end
         if (poke && i == 61) begin
            cgr_req = 1'b0; sqg_req = 1'b0; start = 1'b0;
         end
         tick();
         check("clr_wr_en",   ram_wr_en,   1);
         check("clr_wr_addr", ram_wr_addr, i);
         check("clr_wr_data", ram_wr_data, 0);
      end
      check("ready_after_sweep", ready, 1);
      check("clr_busy_after_sweep", clr_busy, 0);
   endtask

   initial begin
      // ---------------- reset ----------------
      tick(); tick();
      RST = 1'b0;
      check("rst_wr_en",   ram_wr_en,   0);
      check("rst_wr_addr", ram_wr_addr, 0);
      check("rst_wr_data", ram_wr_data, 0);
      check("rst_done",    done,        0);
      check("rst_clr_busy", clr_busy,   0);
      check("rst_ready",   ready,       0);
      // stop in IDLE is ignored
      stop = 1'b1; tick(); stop = 1'b0;
      check("idle_stop_ignored", {clr_busy, ready}, 0);

      // ---------------- first sweep with ignored controls ----------------
      start = 1'b1; tick(); start = 1'b0;
      sweep(-1, 1'b1);

      // ---------------- contention from reset pointer ----------------
      cgr_req = 1'b1; sqg_req = 1'b1;
      cgr_addr = 8'h21; sqg_addr = 8'h42;
      for (int k = 0; k < 4; k++) begin
         cgr_data = 8'hA0 + k[7:0];
         sqg_data = 8'hB0 + k[7:0];
         #1;
         check("cont_cgr_gnt", cgr_gnt, (k % 2 == 0));
         check("cont_sqg_gnt", sqg_gnt, (k % 2 == 1));
         tick();
         check("cont_wr_en", ram_wr_en, 1);
         check("cont_wr_addr", ram_wr_addr, (k % 2 == 0) ? 32'h21 : 32'h42);
         check("cont_wr_data", ram_wr_data, (k % 2 == 0) ? 32'hA0 + k : 32'hB0 + k);
      end
      cgr_req = 1'b0; sqg_req = 1'b0;
      tick();
      check("idle_wr_en", ram_wr_en, 0);
      check("hold_wr_addr", ram_wr_addr, 8'h42);
      check("hold_wr_data", ram_wr_data, 8'hB3);

      // ---------------- single CGR requester ----------------
      cgr_req = 1'b1; cgr_addr = 8'h12; cgr_data = 8'h05;
      #1;
      check("single_cgr_gnt", cgr_gnt, 1);
      check("single_sqg_gnt", sqg_gnt, 0);
      tick();
      // CGR keeps requesting; SQG joins. Pointer now favours SQG.
      sqg_req = 1'b1; sqg_addr = 8'hFE; sqg_data = 8'h77;
      check("single_wr_en",   ram_wr_en,   1);
      check("single_wr_addr", ram_wr_addr, 8'h12);
      check("single_wr_data", ram_wr_data, 8'h05);
      cgr_data = 8'h06;
      #1;
      check("rr_sqg_gnt", sqg_gnt, 1);
      check("rr_cgr_gnt", cgr_gnt, 0);
      tick();
      sqg_req = 1'b0;
      check("rr_wr_addr", ram_wr_addr, 8'hFE);
      check("rr_wr_data", ram_wr_data, 8'h77);
      #1;
      check("cgr_after_sqg_gnt", cgr_gnt, 1);
      tick();
      cgr_req = 1'b0;
      check("cgr_after_sqg_data", ram_wr_data, 8'h06);

      // withdrawn request: no grant recorded as a write after drop
      sqg_req = 1'b1; sqg_addr = 8'h33; sqg_data = 8'h44;
      #1;
      sqg_req = 1'b0;
      #1;
      check("withdraw_gnt", sqg_gnt, 0);
      tick();
      check("withdraw_wr_en", ram_wr_en, 0);

      // start in RUN is ignored
      start = 1'b1; tick(); start = 1'b0;
      check("run_start_ready", ready, 1);
      check("run_start_clr", clr_busy, 0);

      // ---------------- stop priority / flush / done ----------------
      stop = 1'b1; cgr_req = 1'b1; cgr_addr = 8'h55;
      #1;
      check("stop_cgr_gnt", cgr_gnt, 0);
      tick();
      stop = 1'b0; cgr_req = 1'b0;
      check("flush_wr_en", ram_wr_en, 0);
      check("flush_ready", ready, 0);
      check("flush_done",  done, 0);
      #1;
      check("flush_cgr_gnt", cgr_gnt, 0);
      tick();
      check("done_pulse", done, 1);
      check("done_wr_en", ram_wr_en, 0);
      tick();
      check("done_low", done, 0);

      // ---------------- restart, reset mid-clear ----------------
      start = 1'b1; tick(); start = 1'b0;
      sweep(100, 1'b0);
      RST = 1'b1; tick(); RST = 1'b0;
      check("midrst_wr_en",   ram_wr_en,   0);
      check("midrst_wr_addr", ram_wr_addr, 0);
      check("midrst_state",   {clr_busy, ready}, 0);
      tick();
      check("midrst_idle", {clr_busy, ready, ram_wr_en}, 0);

      // ---------------- full re-clear from address 0 ----------------
      start = 1'b1; tick(); start = 1'b0;
      sweep(-1, 1'b0);
      tick();
      check("end_wr_en", ram_wr_en, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
